// File: rtl/seq_gen_tx.sv
// Framed serial transmitter: each accepted payload word goes out MSB first
// as SYNC_PATTERN header followed by the payload, on a registered bit line.
module seq_gen_tx #(
    parameter int   SYNC_WIDTH    = 5,
    parameter       SYNC_PATTERN  = 5'b10110,
    parameter int   PAYLOAD_WIDTH = 8,
    parameter logic IDLE_BIT      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    input  logic                     payload_valid_i,
    output logic                     payload_ready_o,
    output logic                     data_o,
    output logic                     data_valid_o,
    output logic                     frame_start_o,
    output logic                     busy_o
);

    localparam int MAXW = (SYNC_WIDTH > PAYLOAD_WIDTH) ? SYNC_WIDTH : PAYLOAD_WIDTH;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [SYNC_WIDTH-1:0] PAT       = SYNC_WIDTH'(SYNC_PATTERN);
    localparam logic [CW-1:0]         SYNC_LAST = CW'(SYNC_WIDTH - 1);
    localparam logic [CW-1:0]         PAY_LAST  = CW'(PAYLOAD_WIDTH - 1);

    generate
        if (SYNC_WIDTH < 1) begin : g_bad_sync_w
            $error("seq_gen_tx: SYNC_WIDTH must be >= 1");
        end
        if (PAYLOAD_WIDTH < 1) begin : g_bad_pay_w
            $error("seq_gen_tx: PAYLOAD_WIDTH must be >= 1");
        end
        if ($bits(SYNC_PATTERN) > SYNC_WIDTH) begin : g_bad_pat
            $error("seq_gen_tx: SYNC_PATTERN wider than SYNC_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SYNC_WIDTH-1:0]    hdr_q, hdr_d;
    logic [PAYLOAD_WIDTH-1:0] sh_q, sh_d;
    logic                     data_d, dv_d, fs_d;
    logic                     accept;

    // Ready also on the last payload bit so back-to-back frames have no gap.
    assign payload_ready_o = !rst_i && ((state_q == S_IDLE) ||
                             ((state_q == S_PAYLOAD) && (cnt_q == PAY_LAST)));
    assign accept = payload_valid_i && payload_ready_o;
    assign busy_o = data_valid_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        sh_d    = sh_q;
        data_d  = data_o;
        dv_d    = data_valid_o;
        fs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_d = IDLE_BIT;
                dv_d   = 1'b0;
                if (accept) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    data_d  = PAT[SYNC_WIDTH-1];
                    hdr_d   = PAT << 1;
                    sh_d    = payload_i;
                    dv_d    = 1'b1;
                    fs_d    = 1'b1;
                end
            end
            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = '0;
                    data_d  = sh_q[PAYLOAD_WIDTH-1];
                    sh_d    = sh_q << 1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    data_d = hdr_q[SYNC_WIDTH-1];
                    hdr_d  = hdr_q << 1;
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == PAY_LAST) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d = S_SYNC;
                        data_d  = PAT[SYNC_WIDTH-1];
                        hdr_d   = PAT << 1;
                        sh_d    = payload_i;
                        dv_d    = 1'b1;
                        fs_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        data_d  = IDLE_BIT;
                        dv_d    = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    data_d = sh_q[PAYLOAD_WIDTH-1];
                    sh_d   = sh_q << 1;
                end
            end
            default: begin
                state_d = S_IDLE;
                data_d  = IDLE_BIT;
                dv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            hdr_q         <= '0;
            sh_q          <= '0;
            data_o        <= IDLE_BIT;
            data_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hdr_q         <= hdr_d;
            sh_q          <= sh_d;
            data_o        <= data_d;
            data_valid_o  <= dv_d;
            frame_start_o <= fs_d;
        end
    end

endmodule
